// File: rtl/irq_prio_ctrl_pkg.sv
// Shared defaults and FSM state encoding for the interrupt priority controller.
package irq_prio_pkg;
  localparam int DEF_N_REQ = 4;
  localparam int DEF_IDX_W = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } irq_state_t;
endpackage

// File: rtl/irq_prio_ctrl_prio_sel.sv
// Combinational highest-index selector: reports the top set bit and whether any bit is set.
module prio_sel #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_vec,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);
  // Scan upward so the last (highest) set bit overrides the lower ones.
  always_comb begin
    o_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (i_vec[i]) o_idx = IDX_W'(i);
  end

  assign o_any = |i_vec;
endmodule

// File: rtl/irq_prio_ctrl.sv
// Sticky-pending interrupt controller with valid/ack grant handshake.
// Optional build macro IRQ_PRIO_CTRL_EDGE_EN: capture only rising edges of req
// instead of levels.
module irq_prio_ctrl
  import irq_prio_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  output logic             irq_valid,
  output logic [IDX_W-1:0] irq_idx,
  input  logic             irq_ack,
  output logic [N_REQ-1:0] pend,
  output logic [N_REQ-1:0] lost,
  input  logic             lost_clr
);
  irq_state_t       r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [N_REQ-1:0] r_pend, r_lost;
  logic [N_REQ-1:0] w_cap, w_clr, w_ovf;
  logic [IDX_W-1:0] w_sel_idx;
  logic             w_sel_any;

`ifdef IRQ_PRIO_CTRL_EDGE_EN
  logic [N_REQ-1:0] r_req_q;

  // Previous-cycle copy of req for rising-edge detection.
  always_ff @(posedge clk or posedge rst)
    if (rst) r_req_q <= '0;
    else     r_req_q <= req;

  assign w_cap = req & ~r_req_q & mask;
`else
  assign w_cap = req & mask;
`endif

  // Only enabled pending bits compete for the grant.
  prio_sel #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_sel (
    .i_vec (r_pend & mask),
    .o_idx (w_sel_idx),
    .o_any (w_sel_any)
  );

  // Next-state, latched index and clear-on-ack decode; ack outside GRANT does nothing.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_clr       = '0;
    irq_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sel_any) begin
          w_idx_nxt   = w_sel_idx;
          w_state_nxt = GRANT;
        end
      end
      GRANT: begin
        irq_valid = 1'b1;
        if (irq_ack) begin
          w_clr[r_idx] = 1'b1;
          w_state_nxt  = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A new capture on a still-pending bit that is not being serviced is an overflow.
  assign w_ovf = w_cap & r_pend & ~w_clr;

  // FSM state and the presented index.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end

  // Pending and lost vectors: capture beats clear, overflow beats lost_clr.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_pend <= '0;
      r_lost <= '0;
    end else begin
      r_pend <= (r_pend & ~w_clr) | w_cap;
      r_lost <= (lost_clr ? '0 : r_lost) | w_ovf;
    end

  assign irq_idx = r_idx;
  assign pend    = r_pend;
  assign lost    = r_lost;
endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Directed + randomized bench for irq_prio_ctrl against a per-channel reference model.
module tb_irq_prio_ctrl;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req, mask, pend, lost;
  logic         irq_valid, irq_ack, lost_clr;
  logic [1:0]   irq_idx;

  int checks   = 0;
  int failures = 0;

  // reference model state, one entry per channel
  bit m_pend [N];
  bit m_lost [N];
  bit m_prev [N];
  bit m_valid;
  int m_idx;

  irq_prio_ctrl dut (
    .clk(clk), .rst(rst), .req(req), .mask(mask),
    .irq_valid(irq_valid), .irq_idx(irq_idx), .irq_ack(irq_ack),
    .pend(pend), .lost(lost), .lost_clr(lost_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] vec(input bit a [N]);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_lost[i] = 0; m_prev[i] = 0;
    end
    m_valid = 0;
    m_idx   = 0;
  endtask

  // One clock of the specified behaviour, using the inputs present before the edge.
  task automatic model_step();
    bit cap [N];
    bit np  [N];
    int acked;
    int pick;
    acked = (m_valid && irq_ack) ? m_idx : -1;
    for (int i = 0; i < N; i++) begin
`ifdef IRQ_PRIO_CTRL_EDGE_EN
      cap[i] = req[i] && mask[i] && !m_prev[i];
`else
      cap[i] = req[i] && mask[i];
`endif
      if (cap[i] && m_pend[i] && i != acked) m_lost[i] = 1;
      else if (lost_clr)                     m_lost[i] = 0;
      np[i] = cap[i] ? 1'b1 : ((i == acked) ? 1'b0 : m_pend[i]);
    end
    if (m_valid) begin
      if (irq_ack) m_valid = 0;
    end else begin
      pick = -1;
      for (int i = 0; i < N; i++)
        if (m_pend[i] && mask[i]) pick = i;
      if (pick >= 0) begin
        m_valid = 1;
        m_idx   = pick;
      end
    end
    for (int i = 0; i < N; i++) begin
      m_pend[i] = np[i];
      m_prev[i] = req[i];
    end
  endtask

  task automatic compare_all(input string tag);
    chk({tag, ".valid"}, 32'(irq_valid), 32'(m_valid));
    if (m_valid) chk({tag, ".idx"}, 32'(irq_idx), 32'(m_idx));
    chk({tag, ".pend"}, 32'(pend), 32'(vec(m_pend)));
    chk({tag, ".lost"}, 32'(lost), 32'(vec(m_lost)));
  endtask

  // Apply inputs, advance one edge, compare DUT with model 1 time unit later.
  task automatic cyc(input string tag, input logic [N-1:0] r, input logic [N-1:0] m,
                     input logic a, input logic lc);
    req = r; mask = m; irq_ack = a; lost_clr = lc;
    model_step();
    @(posedge clk);
    #1;
    compare_all(tag);
  endtask

  initial begin
    rst = 1'b1; req = '0; mask = '1; irq_ack = 1'b0; lost_clr = 1'b0;
    model_reset();
    #1;
    // async reset seen with no clock edge yet
    chk("reset.valid", 32'(irq_valid), 32'd0);
    chk("reset.idx",   32'(irq_idx),   32'd0);
    chk("reset.pend",  32'(pend),      32'd0);
    chk("reset.lost",  32'(lost),      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // single pulse on channel 2
    cyc("t1.cap", 4'b0100, 4'b1111, 0, 0);
    chk("t1.pend0100", 32'(pend), 32'h4);
    cyc("t1.grant", 4'b0000, 4'b1111, 0, 0);
    chk("t1.idx2", 32'(irq_idx), 32'd2);
    chk("t1.valid1", 32'(irq_valid), 32'd1);
    cyc("t1.ack", 4'b0000, 4'b1111, 1, 0);
    chk("t1.pend0", 32'(pend), 32'h0);

    // priority ordering 3,1,0 with immediate ack
    cyc("t2.cap", 4'b1011, 4'b1111, 0, 0);
    cyc("t2.g3", 4'b0000, 4'b1111, 0, 0);
    chk("t2.idx3", 32'(irq_idx), 32'd3);
    cyc("t2.a3", 4'b0000, 4'b1111, 1, 0);
    chk("t2.gap1", 32'(irq_valid), 32'd0);
    cyc("t2.g1", 4'b0000, 4'b1111, 0, 0);
    chk("t2.idx1", 32'(irq_idx), 32'd1);
    cyc("t2.a1", 4'b0000, 4'b1111, 1, 0);
    cyc("t2.g0", 4'b0000, 4'b1111, 0, 0);
    chk("t2.idx0", 32'(irq_idx), 32'd0);
    cyc("t2.a0", 4'b0000, 4'b1111, 1, 0);
    cyc("t2.idle", 4'b0000, 4'b1111, 0, 0);

    // masked capture, then unmasked channel 0
    cyc("t3.mcap", 4'b1000, 4'b0111, 0, 0);
    cyc("t3.none", 4'b0000, 4'b0111, 0, 0);
    chk("t3.nograntv", 32'(irq_valid), 32'd0);
    cyc("t3.cap0", 4'b0001, 4'b1111, 0, 0);
    cyc("t3.g0", 4'b0000, 4'b1111, 0, 0);
    chk("t3.idx0", 32'(irq_idx), 32'd0);
    cyc("t3.a0", 4'b0000, 4'b1111, 1, 0);

    // overflow on channel 1, lost_clr, then set-wins on ack
    cyc("t4.p1", 4'b0010, 4'b1111, 0, 0);
    cyc("t4.w1", 4'b0000, 4'b1111, 0, 0);
    cyc("t4.w2", 4'b0000, 4'b1111, 0, 0);
    cyc("t4.p2", 4'b0010, 4'b1111, 0, 0);
    chk("t4.lost0010", 32'(lost), 32'h2);
    cyc("t4.clr", 4'b0000, 4'b1111, 0, 1);
    chk("t4.lost0", 32'(lost), 32'h0);
    cyc("t4.setwins", 4'b0010, 4'b1111, 1, 0);
    chk("t4.pend1kept", 32'(pend[1]), 32'd1);
    chk("t4.lost1clr", 32'(lost[1]), 32'd0);

    // no preemption: grant idx 1, higher request waits
    cyc("t5.g1", 4'b0000, 4'b1111, 0, 0);
    chk("t5.idx1", 32'(irq_idx), 32'd1);
    cyc("t5.p3", 4'b1000, 4'b1111, 0, 0);
    cyc("t5.hold", 4'b0000, 4'b1111, 0, 0);
    chk("t5.stay1", 32'(irq_idx), 32'd1);
    cyc("t5.a1", 4'b0000, 4'b1111, 1, 0);
    cyc("t5.g3", 4'b0000, 4'b1111, 0, 0);
    chk("t5.idx3", 32'(irq_idx), 32'd3);

    // reset in the middle of a grant takes effect without a clock edge
    rst = 1'b1; irq_ack = 1'b0;
    model_reset();
    #1;
    chk("t6.valid0", 32'(irq_valid), 32'd0);
    chk("t6.pend0", 32'(pend), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // held request on channel 2 for 10 cycles, never acked
    for (int k = 0; k < 10; k++) cyc("t7.hold", 4'b0100, 4'b1111, 0, 0);
`ifdef IRQ_PRIO_CTRL_EDGE_EN
    chk("t7.lost", 32'(lost), 32'h0);
`else
    chk("t7.lost", 32'(lost), 32'h4);
`endif
    chk("t7.idx2", 32'(irq_idx), 32'd2);
    cyc("t7.a2", 4'b0000, 4'b1111, 1, 0);
    cyc("t7.after", 4'b0000, 4'b1111, 0, 0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      logic [N-1:0] r, m;
      r = N'($urandom) & N'($urandom);
      m = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      cyc("rnd", r, m, m_valid && ($urandom_range(0, 2) != 0),
          $urandom_range(0, 15) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
